// File: rtl/fifo_arbiter_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fifo_arbiter_pkg : shared types and constants for the N-channel FIFO arbiter
// Rev 1.0
// -----------------------------------------------------------------------------
package fifo_arbiter_pkg;

  localparam logic ARB_MODE_RR    = 1'b0;
  localparam logic ARB_MODE_FIXED = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Index width that stays legal for a single-entry range
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_arbiter_next_sel.sv
`default_nettype none
// -----------------------------------------------------------------------------
// arb_next_sel : rotating / fixed priority encoder over the eligible mask
// Rev 1.0
// -----------------------------------------------------------------------------
module arb_next_sel
  import fifo_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] elig,
  input  logic [IDX_W-1:0]  start,
  input  logic              mode,
  output logic              found,
  output logic [IDX_W-1:0]  idx
);

  logic [IDX_W-1:0] w_base;
  logic [IDX_W:0]   w_pos;

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_pos  = '0;
    // Fixed priority is a rotating scan that always starts at channel 0
    w_base = (mode == ARB_MODE_RR) ? start : '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_pos = {1'b0, w_base} + (IDX_W+1)'(k);
      if (w_pos >= (IDX_W+1)'(NUM_CH)) begin
        w_pos = w_pos - (IDX_W+1)'(NUM_CH);
      end
      if (!found && elig[w_pos[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = w_pos[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fifo_arbiter : merges NUM_CH FWFT source FIFOs onto one FWFT sink port
// Rev 1.0
// -----------------------------------------------------------------------------
module fifo_arbiter
  import fifo_arbiter_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                         BUS_CLK,
  input  logic                         BUS_RST_B,
  input  logic                         ARB_MODE,
  input  logic [NUM_CH-1:0]            CH_ENABLE,
  input  logic [NUM_CH-1:0]            CH_EMPTY,
  input  logic [NUM_CH*DATA_WIDTH-1:0] CH_DATA,
  output logic [NUM_CH-1:0]            CH_READ,
  input  logic                         FIFO_READ,
  output logic                         FIFO_EMPTY,
  output logic [DATA_WIDTH-1:0]        FIFO_DATA,
  output logic                         GRANT_VALID,
  output logic [$clog2(NUM_CH)-1:0]    GRANT_IDX,
  output logic                         READ_ERROR
);

  localparam int IDX_W = clog2_min1(NUM_CH);
  localparam int CNT_W = clog2_min1(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = (MAX_BURST == 0) ? '0 : CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CH - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             rd_err_q;

  logic [DATA_WIDTH-1:0] w_ch_data [NUM_CH];
  logic [NUM_CH-1:0]     w_elig, w_grant_oh, w_sel_elig;
  logic                  w_active, w_sink_empty, w_pop, w_burst_rel, w_drain_rel;
  logic [IDX_W-1:0]      w_base, w_start, w_sel_idx;
  logic                  w_found;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
      assign w_ch_data[i] = CH_DATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // The sink is gated during reset so no pop can escape in the reset cycle
  assign w_active     = (state_q == ST_GRANT) && BUS_RST_B;
  assign w_elig       = CH_ENABLE & ~CH_EMPTY;
  assign w_grant_oh   = NUM_CH'(1) << grant_q;
  assign w_sink_empty = w_active ? (CH_EMPTY[grant_q] | ~CH_ENABLE[grant_q]) : 1'b1;
  assign w_pop        = w_active & FIFO_READ & ~w_sink_empty;
  assign w_burst_rel  = (MAX_BURST != 0) && w_pop && (cnt_q == BURST_LAST);
  assign w_drain_rel  = w_active & w_sink_empty;

  // A burst-limited channel steps aside only when someone else is waiting
  assign w_sel_elig = (w_burst_rel && |(w_elig & ~w_grant_oh)) ? (w_elig & ~w_grant_oh) : w_elig;
  assign w_base     = (state_q == ST_GRANT) ? grant_q : last_q;
  assign w_start    = (w_base == LAST_IDX) ? '0 : w_base + 1'b1;

  arb_next_sel #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_next_sel (
    .elig  (w_sel_elig),
    .start (w_start),
    .mode  (ARB_MODE),
    .found (w_found),
    .idx   (w_sel_idx)
  );

  assign CH_READ     = w_pop ? w_grant_oh : '0;
  assign FIFO_EMPTY  = w_sink_empty;
  assign FIFO_DATA   = w_active ? w_ch_data[grant_q] : '0;
  assign GRANT_VALID = (state_q == ST_GRANT);
  assign GRANT_IDX   = grant_q;
  assign READ_ERROR  = rd_err_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_found) begin
          state_d = ST_GRANT;
          grant_d = w_sel_idx;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (w_pop) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (w_burst_rel || w_drain_rel) begin
          last_d = grant_q;
          if (w_found) begin
            grant_d = w_sel_idx;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_B) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      last_q   <= LAST_IDX;
      cnt_q    <= '0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      rd_err_q <= FIFO_READ & w_sink_empty;
    end
  end

endmodule
`default_nettype wire
